// File: rtl/keypad_move_cmd.sv
// Keypad-to-move command translator: debounces the decoder's sticky key code,
// tracks column selection and pop mode, and issues confirmed moves over valid/ready.
module keypad_move_cmd #(
   parameter int unsigned STABLE_CYCLES = 200000,
   parameter int unsigned NUM_COLS      = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key,
   input  logic       pop_tgl,
   input  logic       move_ready,
   output logic [2:0] sel_col,
   output logic       sel_valid,
   output logic       pop_mode,
   output logic       move_valid,
   output logic [2:0] move_col,
   output logic       move_pop,
   output logic       key_err
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [3:0]  KEY_CONFIRM = 4'hE;

   typedef enum logic [1:0] {IDLE, SETTLE, PEND} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     cand_q, cand_d;
   logic [3:0]     last_key_q, last_key_d;
   logic           pop_last_q, pop_last_d;
   logic           base_q, base_d;
   logic [3:0]     key_q;
   logic           pop_q;

   logic [2:0]     sel_col_q, sel_col_d;
   logic           sel_valid_q, sel_valid_d;
   logic           pop_mode_q, pop_mode_d;
   logic           move_valid_q, move_valid_d;
   logic [2:0]     move_col_q, move_col_d;
   logic           move_pop_q, move_pop_d;
   logic           key_err_q, key_err_d;

   // The decoder output is unreset, so the input stage is sampled regardless of rst_n.
   always_ff @(posedge clk) begin
      key_q <= key;
      pop_q <= pop_tgl;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         cand_q       <= '0;
         last_key_q   <= '0;
         pop_last_q   <= 1'b0;
         base_q       <= 1'b1;
         sel_col_q    <= '0;
         sel_valid_q  <= 1'b0;
         pop_mode_q   <= 1'b0;
         move_valid_q <= 1'b0;
         move_col_q   <= '0;
         move_pop_q   <= 1'b0;
         key_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cand_q       <= cand_d;
         last_key_q   <= last_key_d;
         pop_last_q   <= pop_last_d;
         base_q       <= base_d;
         sel_col_q    <= sel_col_d;
         sel_valid_q  <= sel_valid_d;
         pop_mode_q   <= pop_mode_d;
         move_valid_q <= move_valid_d;
         move_col_q   <= move_col_d;
         move_pop_q   <= move_pop_d;
         key_err_q    <= key_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cand_d       = cand_q;
      last_key_d   = last_key_q;
      pop_last_d   = pop_last_q;
      base_d       = base_q;
      sel_col_d    = sel_col_q;
      sel_valid_d  = sel_valid_q;
      pop_mode_d   = pop_mode_q;
      move_valid_d = move_valid_q;
      move_col_d   = move_col_q;
      move_pop_d   = move_pop_q;
      key_err_d    = 1'b0;

      if (base_q) begin
         last_key_d = key_q;
         pop_last_d = pop_q;
         base_d     = 1'b0;
      end else begin
         if (pop_q != pop_last_q) begin
            pop_last_d = pop_q;
            pop_mode_d = ~pop_mode_q;
         end

         unique case (state_q)
            IDLE: begin
               if (key_q != last_key_q) begin
                  state_d = SETTLE;
                  cand_d  = key_q;
                  cnt_d   = '0;
               end
            end

            SETTLE: begin
               if (key_q != cand_q) begin
                  cand_d = key_q;
                  cnt_d  = '0;
               end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  // A bounce back to the previously committed key is not a press.
                  if (cand_q != last_key_q) begin
                     last_key_d = cand_q;
                     if (cand_q >= 4'd1 && cand_q <= 4'(NUM_COLS)) begin
                        sel_col_d   = 3'(cand_q - 4'd1);
                        sel_valid_d = 1'b1;
                     end else if (cand_q == KEY_CONFIRM && sel_valid_q) begin
                        move_valid_d = 1'b1;
                        move_col_d   = sel_col_q;
                        move_pop_d   = pop_mode_q;
                        state_d      = PEND;
                     end else begin
                        key_err_d = 1'b1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end

            PEND: begin
               // Clearing pop_mode here overrides any toggle seen in the same cycle.
               if (move_ready) begin
                  move_valid_d = 1'b0;
                  sel_valid_d  = 1'b0;
                  pop_mode_d   = 1'b0;
                  state_d      = IDLE;
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   assign sel_col    = sel_col_q;
   assign sel_valid  = sel_valid_q;
   assign pop_mode   = pop_mode_q;
   assign move_valid = move_valid_q;
   assign move_col   = move_col_q;
   assign move_pop   = move_pop_q;
   assign key_err    = key_err_q;

endmodule

// File: tb/tb_keypad_move_cmd.sv
// Bench for keypad_move_cmd: run-length behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized key/pop/ready traffic.
module tb_keypad_move_cmd;

   localparam int unsigned S  = 4;
   localparam int unsigned NC = 7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key;
   logic       pop_tgl;
   logic       move_ready;
   logic [2:0] sel_col;
   logic       sel_valid;
   logic       pop_mode;
   logic       move_valid;
   logic [2:0] move_col;
   logic       move_pop;
   logic       key_err;

   int errors = 0;
   int checks = 0;

   keypad_move_cmd #(.STABLE_CYCLES(S), .NUM_COLS(NC)) dut (
      .clk(clk), .rst_n(rst_n), .key(key), .pop_tgl(pop_tgl), .move_ready(move_ready),
      .sel_col(sel_col), .sel_valid(sel_valid), .pop_mode(pop_mode),
      .move_valid(move_valid), .move_col(move_col), .move_pop(move_pop), .key_err(key_err)
   );

   always #5 clk = ~clk;

   // Model: a key is accepted when its registered value has been seen unchanged on
   // S+1 consecutive tracking edges (edges not spent waiting on a pending move).
   logic       m_known = 1'b0;
   logic       m_base;
   logic [3:0] m_kr, m_lastk, m_runkey;
   logic       m_pr, m_poplast;
   int         m_run;
   logic [2:0] m_selc, m_mcol;
   logic       m_selv, m_popm, m_mv, m_mpop, m_err, m_oldpm;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_known = 1'b1;
         m_base = 1'b1; m_lastk = 4'd0; m_poplast = 1'b0; m_run = 0; m_runkey = 4'd0;
         m_selc = 3'd0; m_selv = 1'b0; m_popm = 1'b0; m_mv = 1'b0;
         m_mcol = 3'd0; m_mpop = 1'b0; m_err = 1'b0;
      end else if (m_known) begin
         m_err = 1'b0;
         if (m_base) begin
            m_lastk = m_kr; m_poplast = m_pr; m_base = 1'b0; m_run = 0;
         end else begin
            m_oldpm = m_popm;
            if (m_pr != m_poplast) begin
               m_poplast = m_pr;
               m_popm = ~m_popm;
            end
            if (m_mv) begin
               m_run = 0;
               if (move_ready) begin
                  m_mv = 1'b0; m_selv = 1'b0; m_popm = 1'b0;
               end
            end else begin
               if (m_run > 0 && m_kr == m_runkey) m_run = m_run + 1;
               else begin
                  m_run = 1; m_runkey = m_kr;
               end
               if (m_run == S + 1 && m_kr != m_lastk) begin
                  m_lastk = m_kr;
                  if (m_kr >= 4'd1 && m_kr <= 4'(NC)) begin
                     m_selc = 3'(m_kr - 4'd1); m_selv = 1'b1;
                  end else if (m_kr == 4'hE && m_selv) begin
                     m_mv = 1'b1; m_mcol = m_selc; m_mpop = m_oldpm;
                  end else m_err = 1'b1;
               end
            end
         end
      end
      m_kr = key;
      m_pr = pop_tgl;
   end

   logic [11:0] dut_vec, mdl_vec;
   assign dut_vec = {sel_col, sel_valid, pop_mode, move_valid, move_col, move_pop, key_err};
   assign mdl_vec = {m_selc, m_selv, m_popm, m_mv, m_mcol, m_mpop, m_err};

   always @(negedge clk) begin
      if (m_known) begin
         checks++;
         if (dut_vec !== mdl_vec) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual={col,sv,pm,mv,mcol,mp,err}=%b required=%b",
                     $time, dut_vec, mdl_vec);
         end
      end
   end

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   int hold;
   int r;

   initial begin
      rst_n = 1'b0; key = 4'h3; pop_tgl = 1'b0; move_ready = 1'b0;
      tick(3);
      chk("reset_outputs", dut_vec, 12'h000);
      rst_n = 1'b1;
      tick(10);
      chk("baseline_no_sel", 12'(sel_valid), 12'd0);
      chk("baseline_no_err", 12'(key_err), 12'd0);
      key = 4'h5;
      tick(5);
      chk("deb_before", 12'(sel_valid), 12'd0);
      tick(1);
      chk("deb_sel_valid", 12'(sel_valid), 12'd1);
      chk("deb_sel_col", 12'(sel_col), 12'd4);
      chk("model_sel_col", 12'(m_selc), 12'd4);

      key = 4'h2; tick(1); key = 4'h6; tick(1); key = 4'h2; tick(1); key = 4'h6;
      tick(5);
      chk("bounce_hold", 12'(sel_col), 12'd4);
      tick(1);
      chk("bounce_commit", 12'(sel_col), 12'd5);

      key = 4'h4; tick(6);
      chk("sel4_col", 12'(sel_col), 12'd3);
      pop_tgl = ~pop_tgl; tick(1);
      chk("pop_lat_early", 12'(pop_mode), 12'd0);
      tick(1);
      chk("pop_lat", 12'(pop_mode), 12'd1);
      key = 4'hE; tick(6);
      chk("move_issue", {move_valid, move_col, move_pop}, {7'd0, 1'b1, 3'd3, 1'b1});
      chk("model_move", {m_mv, m_mcol, m_mpop}, {7'd0, 1'b1, 3'd3, 1'b1});
      tick(10);
      chk("move_hold", {move_valid, move_col, move_pop}, {7'd0, 1'b1, 3'd3, 1'b1});
      move_ready = 1'b1; tick(1); move_ready = 1'b0;
      chk("handshake_clear", {move_valid, sel_valid, pop_mode}, 12'd0);

      rst_n = 1'b0; key = 4'h1; tick(2); rst_n = 1'b1; tick(5);
      key = 4'hE; tick(5);
      chk("err_before", 12'(key_err), 12'd0);
      tick(1);
      chk("err_nosel", {key_err, sel_valid}, 12'b10);
      tick(1);
      chk("err_single", 12'(key_err), 12'd0);
      key = 4'h9; tick(6);
      chk("err_9", {key_err, sel_valid}, 12'b10);
      key = 4'h3; tick(6);
      chk("sel3", {sel_valid, sel_col}, {8'd0, 1'b1, 3'd2});
      key = 4'h9; tick(6);
      chk("err_9_keep", {key_err, sel_valid, sel_col}, {7'd0, 1'b1, 1'b1, 3'd2});
      key = 4'h0; tick(6);
      chk("err_0", {key_err, sel_col}, {8'd0, 1'b1, 3'd2});
      key = 4'h8; tick(6);
      chk("err_8", {key_err, sel_col}, {8'd0, 1'b1, 3'd2});
      key = 4'h7; tick(6);
      chk("sel7_col", {key_err, sel_col}, {8'd0, 1'b0, 3'd6});

      key = 4'h2; tick(6);
      key = 4'hE; tick(6);
      chk("pend_move", {move_valid, move_col, move_pop}, {7'd0, 1'b1, 3'd1, 1'b0});
      key = 4'h7; pop_tgl = ~pop_tgl; tick(3);
      chk("pend_pop", {pop_mode, move_pop, move_valid, sel_col}, {6'd0, 1'b1, 1'b0, 1'b1, 3'd1});
      pop_tgl = ~pop_tgl; tick(1);
      move_ready = 1'b1; tick(1); move_ready = 1'b0;
      chk("absorb_pop", {move_valid, pop_mode, sel_valid}, 12'd0);
      tick(4);
      chk("post_pend_wait", 12'(sel_valid), 12'd0);
      tick(1);
      chk("post_pend_sel", {sel_valid, sel_col}, {8'd0, 1'b1, 3'd6});
      tick(3);
      chk("pop_stays_clear", 12'(pop_mode), 12'd0);

      key = 4'h3; tick(3);
      rst_n = 1'b0; tick(1);
      chk("rst_mid_settle", dut_vec, 12'h000);
      rst_n = 1'b1; tick(10);
      chk("rst_settle_base", {sel_valid, key_err}, 12'd0);
      key = 4'h1; tick(6);
      key = 4'hE; tick(6);
      chk("pend_again", 12'(move_valid), 12'd1);
      rst_n = 1'b0; tick(1);
      chk("rst_mid_pend", dut_vec, 12'h000);
      rst_n = 1'b1; tick(10);
      chk("rst_pend_base", {move_valid, sel_valid, key_err}, 12'd0);

      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         if (hold == 0) begin
            r = int'($urandom_range(0, 9));
            if (r < 7) key = 4'(r + 1);
            else if (r == 7) key = 4'hE;
            else key = 4'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 9));
         end else hold--;
         if ($urandom_range(0, 11) == 0) pop_tgl = ~pop_tgl;
         move_ready = ($urandom_range(0, 3) == 0);
      end
      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_move_cmd.md
# keypad_move_cmd

Converts the keypad decoder's sticky 4-bit key code and pop-toggle level into debounced, handshaken Connect-4 move commands. Sits directly downstream of the keypad decoder and upstream of the game-board controller. Digit keys pick a column, the pop toggle arms pop mode, and key E confirms. Each confirmed move is issued once over a valid/ready handshake.

## Interface
- STABLE_CYCLES, 200000, cycles a new key code must hold before it is accepted (2 ms at 100 MHz); ≥1
- NUM_COLS, 7, number of board columns; legal range 1..7
- clk  in  1  100 MHz system clock
- rst_n  in  1  reset, synchronous and active-low
- key  in  4  key code from the decoder; holds the last key pressed; no valid strobe
- pop_tgl  in  1  decoder pop output; each level change is one pop-key press
- move_ready  in  1  board controller accepts the move this cycle
- sel_col  out  3  currently selected column, 0-based
- sel_valid  out  1  sel_col holds a selection
- pop_mode  out  1  next move is a pop rather than a drop
- move_valid  out  1  move command pending
- move_col  out  3  column of the pending move
- move_pop  out  1  pending move is a pop
- key_err  out  1  one-cycle pulse for an illegal or out-of-order key

## Operation
- Input register: key_r and pop_r sample key and pop_tgl every cycle.
- Baseline: on the first cycle after reset release, last_key←key_r and pop_last←pop_r, and no event is raised. The decoder output is unreset, so its power-up value is never treated as a press.
- A key event is a change in value only. Pressing the same key twice with no other key between produces one event.
- States: IDLE, SETTLE, PEND.
- IDLE:
  - key_r≠last_key → SETTLE, cand←key_r, cnt←0.
- SETTLE:
  - key_r≠cand → cand←key_r, cnt←0. Stay in SETTLE.
  - key_r==cand and cnt==STABLE_CYCLES-1 → commit: last_key←cand, decode cand, go to IDLE (or PEND; see confirm below).
  - Otherwise cnt++.
  - If the committed cand equals last_key (bounce back to the old key), raise no event and go to IDLE.
- Decode on commit:
  - 1..NUM_COLS → sel_col←cand-1, sel_valid←1. Reselection overwrites the previous selection.
  - 0xE with sel_valid=1 → move_valid←1, move_col←sel_col, move_pop←pop_mode, go to PEND.
  - 0xE with sel_valid=0 → key_err pulse.
  - Any other code, including 0 and NUM_COLS+1..0xD/0xF → key_err pulse. Selection is unchanged.
- Pop: pop_r≠pop_last → pop_last←pop_r, pop_mode←~pop_mode. This is honoured in IDLE and SETTLE.
- PEND:
  - move_valid, move_col and move_pop are held stable until move_ready=1.
  - Key changes are not tracked; last_key is frozen. After returning to IDLE, any difference is debounced normally.
  - Pop edges update pop_last and pop_mode, but move_pop stays frozen.
- Handshake cycle (move_valid & move_ready):
  - move_valid←0, sel_valid←0, pop_mode←0, go to IDLE.
  - A pop edge in the same cycle is absorbed: pop_last is updated, and the clear to pop_mode wins.
- cnt width is $clog2(STABLE_CYCLES+1). cnt never exceeds STABLE_CYCLES-1.

## Timing
- Reset (rst_n=0 at a clk edge) sets:
  - all outputs to 0;
  - state to IDLE;
  - cnt, cand, last_key and pop_last to 0;
  - the baseline-pending flag to 1.
- Reset mid-SETTLE or mid-PEND aborts immediately. The pending move is dropped without a handshake.
- Debounce latency: if key is new before edge 1 and then stays stable, sel_* and move_* update at edge STABLE_CYCLES+2. key_err is high for the single cycle after that edge.
- Pop latency: pop_tgl change before edge 1 → pop_mode flips at edge 2.
- move_valid may drop only in the cycle after a handshake edge. It never drops without move_ready.
- move_ready while move_valid=0 is ignored.
- All outputs are registered. There is no combinational input→output path.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset with key=0x3 held → no sel_valid and no key_err ever. Then change key to 0x5 → sel_valid=1, sel_col=4 at edge 6.
- Bounce: key 0x2, 0x6, 0x2, then stable 0x6 → exactly one commit (sel_col=5), and it occurs 6 edges after the last change.
- Select 0x4, toggle pop_tgl once, press 0xE → move_valid=1, move_col=3, move_pop=1. Hold move_ready=0 for 10 cycles → outputs stable. Pulse move_ready → move_valid, sel_valid and pop_mode all 0 the next cycle.
- From the baseline key 0x1, press 0xE with no selection → key_err single pulse. Press 0x9 → key_err pulse with sel_valid unchanged.
- During PEND, change key to 0x7 and toggle pop_tgl, then handshake → pop_mode=0 (toggle absorbed). Key 0x7 is debounced after return to IDLE → sel_col=6.
- Reset asserted mid-SETTLE and mid-PEND → all outputs 0 the next cycle. The first post-reset key value is baselined with no event.
